// File: rtl/br_rs_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : br_rs_scheduler_if
// Description : Dispatch, CDB, branch-unit and result bundle of the branch
//               reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_rs_scheduler_if #(
    parameter int ROB_W = 5,
    parameter int TAG_W = 6
);
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [31:0]       disp_pc;
    logic [31:0]       disp_imm;
    logic [2:0]        disp_funct3;
    logic [1:0]        disp_jsel;
    logic [ROB_W-1:0]  disp_rob;
    logic [TAG_W-1:0]  disp_s1_tag;
    logic [TAG_W-1:0]  disp_s2_tag;
    logic              disp_s1_rdy;
    logic              disp_s2_rdy;
    logic [31:0]       disp_s1_v;
    logic [31:0]       disp_s2_v;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              fu_valid;
    logic [31:0]       fu_a;
    logic [31:0]       fu_b;
    logic [31:0]       fu_pc;
    logic [31:0]       fu_imm;
    logic [2:0]        fu_funct3;
    logic [1:0]        fu_jsel;
    logic              fu_br_en;
    logic [31:0]       fu_target;
    logic              res_valid;
    logic              res_ready;
    logic [ROB_W-1:0]  res_rob;
    logic              res_br_en;
    logic [31:0]       res_target;

    modport master (
        output flush, disp_valid, disp_pc, disp_imm, disp_funct3, disp_jsel,
               disp_rob, disp_s1_tag, disp_s2_tag, disp_s1_rdy, disp_s2_rdy,
               disp_s1_v, disp_s2_v, cdb_valid, cdb_tag, cdb_data,
               fu_br_en, fu_target, res_ready,
        input  disp_ready, fu_valid, fu_a, fu_b, fu_pc, fu_imm, fu_funct3,
               fu_jsel, res_valid, res_rob, res_br_en, res_target
    );

    modport slave (
        input  flush, disp_valid, disp_pc, disp_imm, disp_funct3, disp_jsel,
               disp_rob, disp_s1_tag, disp_s2_tag, disp_s1_rdy, disp_s2_rdy,
               disp_s1_v, disp_s2_v, cdb_valid, cdb_tag, cdb_data,
               fu_br_en, fu_target, res_ready,
        output disp_ready, fu_valid, fu_a, fu_b, fu_pc, fu_imm, fu_funct3,
               fu_jsel, res_valid, res_rob, res_br_en, res_target
    );
endinterface
`default_nettype wire

// File: rtl/br_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : br_rs_scheduler
// Description : Collapsing-queue reservation station and oldest-first issue
//               scheduler for the branch/jump address unit.
// Revision    : 1.0 - initial release
// ============================================================================
module br_rs_scheduler #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5,
    parameter int TAG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    br_rs_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [2:0]       funct3;
        logic [1:0]       jsel;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] s1_tag;
        logic             s1_rdy;
        logic [31:0]      s1_v;
        logic [TAG_W-1:0] s2_tag;
        logic             s2_rdy;
        logic [31:0]      s2_v;
    } ent_t;

    ent_t             r_ent  [DEPTH];
    ent_t             w_wake [DEPTH];
    ent_t             w_nxt  [DEPTH];
    ent_t             w_new;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_wr_idx;
    logic [DEPTH-1:0] w_elig;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;
    logic             w_issue;
    logic             w_disp;
    logic             w_res_free;

    logic             r_res_valid;
    logic [ROB_W-1:0] r_res_rob;
    logic             r_res_br_en;
    logic [31:0]      r_res_target;

    // Eligibility and oldest-first pick
    always_comb begin
        w_res_free = !r_res_valid || bus.res_ready;
        w_found    = 1'b0;
        w_sel      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_elig[i] = (CNT_W'(i) < r_count) && r_ent[i].s1_rdy &&
                        r_ent[i].s2_rdy && w_res_free;
            if (w_elig[i] && !w_found) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
        w_issue = w_found;
    end

    assign bus.disp_ready = (r_count < c_depth);
    assign w_disp         = bus.disp_valid && bus.disp_ready;

    assign bus.fu_valid   = w_issue;
    assign bus.fu_a       = r_ent[w_sel].s1_v;
    assign bus.fu_b       = r_ent[w_sel].s2_v;
    assign bus.fu_pc      = r_ent[w_sel].pc;
    assign bus.fu_imm     = r_ent[w_sel].imm;
    assign bus.fu_funct3  = r_ent[w_sel].funct3;
    assign bus.fu_jsel    = r_ent[w_sel].jsel;

    assign bus.res_valid  = r_res_valid;
    assign bus.res_rob    = r_res_rob;
    assign bus.res_br_en  = r_res_br_en;
    assign bus.res_target = r_res_target;

    // Incoming op, with same-cycle CDB capture for sources not yet ready
    always_comb begin
        w_new.pc     = bus.disp_pc;
        w_new.imm    = bus.disp_imm;
        w_new.funct3 = bus.disp_funct3;
        w_new.jsel   = bus.disp_jsel;
        w_new.rob    = bus.disp_rob;
        w_new.s1_tag = bus.disp_s1_tag;
        w_new.s2_tag = bus.disp_s2_tag;
        w_new.s1_rdy = bus.disp_s1_rdy ||
                       (bus.cdb_valid && (bus.cdb_tag == bus.disp_s1_tag));
        w_new.s2_rdy = bus.disp_s2_rdy ||
                       (bus.cdb_valid && (bus.cdb_tag == bus.disp_s2_tag));
        w_new.s1_v   = bus.disp_s1_rdy ? bus.disp_s1_v : bus.cdb_data;
        w_new.s2_v   = bus.disp_s2_rdy ? bus.disp_s2_v : bus.cdb_data;
    end

    // Wakeup, then collapse over the issued slot, then append the dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake[i] = r_ent[i];
            if (bus.cdb_valid && (CNT_W'(i) < r_count)) begin
                if (!r_ent[i].s1_rdy && (r_ent[i].s1_tag == bus.cdb_tag)) begin
                    w_wake[i].s1_rdy = 1'b1;
                    w_wake[i].s1_v   = bus.cdb_data;
                end
                if (!r_ent[i].s2_rdy && (r_ent[i].s2_tag == bus.cdb_tag)) begin
                    w_wake[i].s2_rdy = 1'b1;
                    w_wake[i].s2_v   = bus.cdb_data;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = w_wake[i];
        end
        if (w_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= w_sel) begin
                    w_nxt[i] = w_wake[i+1];
                end
            end
        end

        w_wr_idx = r_count - CNT_W'(w_issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp && (CNT_W'(i) == w_wr_idx)) begin
                w_nxt[i] = w_new;
            end
        end

        w_count_nxt = r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_res_valid  <= 1'b0;
            r_res_rob    <= '0;
            r_res_br_en  <= 1'b0;
            r_res_target <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (bus.flush) begin
            // Entry contents are left stale; a zero count marks them all invalid
            r_count     <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt[i];
            end
            if (w_issue) begin
                r_res_valid  <= 1'b1;
                r_res_rob    <= r_ent[w_sel].rob;
                r_res_br_en  <= bus.fu_br_en;
                r_res_target <= bus.fu_target;
            end else if (bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_br_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_rs_scheduler
// Description : Directed self-checking bench for br_rs_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_rs_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    br_rs_scheduler_if #(.ROB_W(5), .TAG_W(6)) bus ();

    br_rs_scheduler #(.DEPTH(4), .ROB_W(5), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Branch unit: funct3 0 = BEQ, else BNE; jumps always take pc+imm
    assign bus.fu_br_en  = (bus.fu_funct3 == 3'd0) ? (bus.fu_a == bus.fu_b)
                                                   : (bus.fu_a != bus.fu_b);
    assign bus.fu_target = ((bus.fu_jsel != 2'd0) || bus.fu_br_en)
                           ? (bus.fu_pc + bus.fu_imm) : (bus.fu_pc + 32'd4);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
    endtask

    task automatic disp_op(input logic [4:0] rob, input logic [31:0] pc, input logic [31:0] imm,
                           input logic s1r, input logic [5:0] s1t, input logic [31:0] s1v,
                           input logic s2r, input logic [5:0] s2t, input logic [31:0] s2v);
        bus.disp_valid  = 1'b1;
        bus.disp_rob    = rob;
        bus.disp_pc     = pc;
        bus.disp_imm    = imm;
        bus.disp_funct3 = 3'd0;
        bus.disp_jsel   = 2'd0;
        bus.disp_s1_rdy = s1r;
        bus.disp_s1_tag = s1t;
        bus.disp_s1_v   = s1v;
        bus.disp_s2_rdy = s2r;
        bus.disp_s2_tag = s2t;
        bus.disp_s2_v   = s2v;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        disp_op(5'd0, 32'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
        bus.disp_valid = 1'b0;
        bus.res_ready  = 1'b1;
        step();
        step();
        check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("rst_res_valid",  32'(bus.res_valid),  32'd0);
        check("rst_fu_valid",   32'(bus.fu_valid),   32'd0);
        check("rst_res_target", bus.res_target,      32'd0);
        rst = 1'b0;
        step();

        // Single BEQ: fu_valid one cycle later, result the cycle after
        disp_op(5'd3, 32'h100, 32'h20, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd5);
        step();
        bus.disp_valid = 1'b0;
        check("beq_fu_valid", 32'(bus.fu_valid), 32'd1);
        check("beq_fu_pc",    bus.fu_pc,         32'h100);
        check("beq_fu_a",     bus.fu_a,          32'd5);
        step();
        check("beq_res_valid",  32'(bus.res_valid), 32'd1);
        check("beq_res_rob",    32'(bus.res_rob),   32'd3);
        check("beq_res_br_en",  32'(bus.res_br_en), 32'd1);
        check("beq_res_target", bus.res_target,     32'h120);
        check("beq_fu_idle",    32'(bus.fu_valid),  32'd0);
        step();
        check("beq_res_clear", 32'(bus.res_valid), 32'd0);

        // Fill with four ops waiting on tag 7, then wake them all at once
        for (int k = 0; k < 4; k++) begin
            disp_op(5'(k), 32'h200 + 32'(k * 4), 32'h40, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd9);
            step();
        end
        bus.disp_valid = 1'b0;
        check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
        check("full_fu_valid",   32'(bus.fu_valid),   32'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd7;
        bus.cdb_data  = 32'd9;
        step();
        bus.cdb_valid = 1'b0;
        check("wake_fu_valid",   32'(bus.fu_valid),   32'd1);
        check("wake_fu_pc0",     bus.fu_pc,           32'h200);
        check("wake_fu_a",       bus.fu_a,            32'd9);
        check("wake_disp_ready", 32'(bus.disp_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("order_res_rob", 32'(bus.res_rob), 32'(k));
            check("order_res_target", bus.res_target, 32'h240 + 32'(k * 4));
            if (k < 3) check("order_fu_pc", bus.fu_pc, 32'h204 + 32'(k * 4));
        end
        check("order_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("order_fu_idle",    32'(bus.fu_valid),   32'd0);
        step();

        // Same-cycle CDB capture at dispatch
        disp_op(5'd5, 32'h300, 32'h8, 1'b1, 6'd0, 32'd1, 1'b0, 6'd12, 32'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd12;
        bus.cdb_data  = 32'h55;
        step();
        idle_in();
        check("cap_fu_valid", 32'(bus.fu_valid), 32'd1);
        check("cap_fu_b",     bus.fu_b,          32'h55);
        step();
        check("cap_res_rob",    32'(bus.res_rob),   32'd5);
        check("cap_res_br_en",  32'(bus.res_br_en), 32'd0);
        check("cap_res_target", bus.res_target,     32'h304);
        step();

        // Backpressure with a second ready op queued
        bus.res_ready = 1'b0;
        disp_op(5'd6, 32'h400, 32'h10, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        step();
        disp_op(5'd7, 32'h500, 32'h20, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
        check("bp_first_issue", 32'(bus.fu_valid), 32'd1);
        step();
        bus.disp_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            check("bp_hold_rob",    32'(bus.res_rob),   32'd6);
            check("bp_hold_target", bus.res_target,     32'h410);
            check("bp_hold_valid",  32'(bus.res_valid), 32'd1);
            check("bp_hold_fu",     32'(bus.fu_valid),  32'd0);
            step();
        end
        bus.res_ready = 1'b1;
        #1;
        check("bp_release_fu", 32'(bus.fu_valid), 32'd1);
        check("bp_release_pc", bus.fu_pc,         32'h500);
        step();
        check("bp_new_valid",  32'(bus.res_valid), 32'd1);
        check("bp_new_rob",    32'(bus.res_rob),   32'd7);
        check("bp_new_target", bus.res_target,     32'h504);
        step();

        // Younger ready entry bypasses an older stalled one
        disp_op(5'd8, 32'h600, 32'h4, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd3);
        step();
        disp_op(5'd9, 32'h700, 32'h4, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd2);
        check("ooo_stalled", 32'(bus.fu_valid), 32'd0);
        step();
        bus.disp_valid = 1'b0;
        check("ooo_fu_valid", 32'(bus.fu_valid), 32'd1);
        check("ooo_fu_pc",    bus.fu_pc,         32'h700);
        step();
        check("ooo_res_rob", 32'(bus.res_rob),  32'd9);
        check("ooo_fu_idle", 32'(bus.fu_valid), 32'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd20;
        bus.cdb_data  = 32'd3;
        step();
        bus.cdb_valid = 1'b0;
        check("ooo_old_pc", bus.fu_pc,          32'h600);
        check("ooo_old_a",  bus.fu_a,           32'd3);
        check("ooo_old_fu", 32'(bus.fu_valid),  32'd1);
        step();
        check("ooo_old_rob",    32'(bus.res_rob), 32'd8);
        check("ooo_old_target", bus.res_target,   32'h604);
        step();

        // Flush with three waiting entries, a held result and a dispatch
        bus.res_ready = 1'b0;
        disp_op(5'd10, 32'h800, 32'h8, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        step();
        for (int k = 0; k < 3; k++) begin
            disp_op(5'(11 + k), 32'h810 + 32'(k * 4), 32'h8, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd0);
            step();
        end
        check("fl_pre_res_valid", 32'(bus.res_valid), 32'd1);
        disp_op(5'd14, 32'h900, 32'h8, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        bus.flush = 1'b1;
        step();
        idle_in();
        check("fl_res_valid",  32'(bus.res_valid),  32'd0);
        check("fl_disp_ready", 32'(bus.disp_ready), 32'd1);
        check("fl_fu_valid",   32'(bus.fu_valid),   32'd0);
        bus.res_ready = 1'b1;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd30;
        bus.cdb_data  = 32'd1;
        step();
        bus.cdb_valid = 1'b0;
        check("fl_no_wake", 32'(bus.fu_valid), 32'd0);

        // Asynchronous reset between edges
        bus.res_ready = 1'b0;
        disp_op(5'd15, 32'hA00, 32'h8, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd4);
        step();
        disp_op(5'd16, 32'hB00, 32'h8, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd4);
        step();
        bus.disp_valid = 1'b0;
        check("ar_pre_valid", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        #1;
        check("ar_pre_fu", 32'(bus.fu_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_res_valid",  32'(bus.res_valid),  32'd0);
        check("ar_res_rob",    32'(bus.res_rob),    32'd0);
        check("ar_res_br_en",  32'(bus.res_br_en),  32'd0);
        check("ar_res_target", bus.res_target,      32'd0);
        check("ar_fu_valid",   32'(bus.fu_valid),   32'd0);
        check("ar_disp_ready", 32'(bus.disp_ready), 32'd1);
        #2;
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/br_rs_scheduler.md
Name: br_rs_scheduler

Overview:
- Reservation station and issue scheduler for the single branch/jump address unit.
- Buffers dispatched branch/JAL/JALR ops and captures source operands from CDB broadcasts.
- Each cycle, issues the oldest fully-ready entry to the unit, then holds the unit's combinational result in an output register until the CDB/ROB consumer accepts it.
- Sits between the dispatch stage and the branch unit; its result output feeds the CDB arbiter.

Parameters:
DEPTH, 4, number of station entries (power of two, >=2)
ROB_W, 5, ROB index width
TAG_W, 6, physical register tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  mispredict flush; discards all entries and the held result
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept an op
disp_pc  in  32  op PC
disp_imm  in  32  op immediate
disp_funct3  in  3  branch compare code
disp_jsel  in  2  jump select (branch / jump / jump_link)
disp_rob  in  ROB_W  ROB index
disp_s1_tag, disp_s2_tag  in  TAG_W  source tags
disp_s1_rdy, disp_s2_rdy  in  1  source value already valid
disp_s1_v, disp_s2_v  in  32  source values when ready
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  32  broadcast value
fu_valid  out  1  operands presented to the unit this cycle
fu_a, fu_b  out  32  source 1 / source 2 values
fu_pc, fu_imm  out  32  PC / immediate of the issued op
fu_funct3  out  3  compare code of the issued op
fu_jsel  out  2  jump select of the issued op
fu_br_en  in  1  unit compare result (combinational, same cycle)
fu_target  in  32  unit next-PC result (combinational, same cycle)
res_valid  out  1  held result valid
res_ready  in  1  consumer accepts result
res_rob  out  ROB_W  ROB index of the result
res_br_en  out  1  taken flag
res_target  out  32  resolved next PC

Behaviour:
- Reset: all entries invalid; count=0; res_valid=0; res_rob, res_br_en, res_target = 0; fu_valid=0; disp_ready=1.
- Storage is a collapsing queue. Index 0 is the oldest entry. Valid entries are always contiguous from index 0.
- disp_ready = (count < DEPTH). It is a registered function of count only and does not depend on same-cycle issue.
- Dispatch fires on disp_valid & disp_ready.
  - The new entry is written at index count, or count-1 if an issue in the same cycle removes an entry.
- Operand capture: a source is stored ready if disp_sX_rdy is set, or if cdb_valid and cdb_tag==disp_sX_tag in the same cycle.
  - When captured via CDB, cdb_data is stored.
- Wakeup: every valid, not-ready source whose tag equals cdb_tag while cdb_valid is set gets ready=1 and value=cdb_data at the clock edge. The entry becomes eligible the following cycle.
- Issue eligibility: entry valid, both sources ready, and (res_valid==0 or res_ready==1).
- Selection: the lowest-index eligible entry. fu_valid=1 and the fu_* outputs carry that entry combinationally.
- Issue fires when fu_valid is set.
  - At the clock edge: res_valid=1; res_rob, res_br_en, res_target are loaded from the entry and fu_br_en/fu_target.
  - The entry is removed and higher entries shift down by one.
- Result handshake: res_* stay stable while res_valid & !res_ready. res_valid clears on res_ready unless a new issue reloads it in the same cycle.
- Latency: op dispatched with both sources ready in cycle N → fu_valid in N+1 → res_valid in N+2.
- Full: count==DEPTH → disp_ready=0. Dispatch is allowed again the cycle after count drops.
- Backpressure: with res_valid=1 and res_ready=0, no issue occurs and entries are held.
- Flush (priority over everything except reset):
  - At the edge: count=0, all entries invalid, res_valid=0.
  - Dispatch and issue in the flush cycle are discarded.
  - fu_valid may be asserted combinationally in the flush cycle, but the edge action ignores it.
- Reset asserted mid-operation returns immediately to the reset state, independent of clk.

Test Plan:
- Reset, then dispatch BEQ (pc=0x100, imm=0x20, rob=3, both srcs ready, 5==5); unit returns br_en=1, target=0x120 → fu_valid in cycle 1, then res_valid=1, res_rob=3, res_target=0x120 in cycle 2.
- Dispatch 4 ops with s1 not ready (tag=7) → disp_ready=0 after the 4th; CDB tag=7, data=9 → all wake, issue in order rob 0,1,2,3 on consecutive cycles with fu_a=9 and res_ready=1.
- Dispatch with disp_s2_tag=12, not ready, while cdb_valid, cdb_tag=12, data=0x55 → entry stored ready; fu_b=0x55 next cycle.
- Hold res_ready=0 for 3 cycles with a second ready entry queued → res_* unchanged, fu_valid=0; release → second op issues the same cycle res_ready=1, and res_valid stays 1 with the new rob.
- Entry 0 not ready, entry 1 ready → entry 1 issues first; the remaining entry shifts to index 0.
- Assert flush with 3 entries and res_valid=1 plus a simultaneous dispatch → next cycle count=0, res_valid=0, disp_ready=1, no fu_valid.
- Assert rst asynchronously between clock edges with entries held → outputs zero immediately.
